// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add/subtract sequencer driving one shared external 1-bit full adder
// Optional zero/neg result flags are enabled by defining SERIAL_ADDER_FLAGS_EN.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             c_out,
    output logic             overflow,
`ifdef SERIAL_ADDER_FLAGS_EN
    output logic             zero,
    output logic             neg,
`endif
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_c_in,
    input  logic             fa_s,
    input  logic             fa_c_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] result_sh_q, result_sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CW-1:0]    count_q, count_d;
    logic             carry_q, carry_d;
    logic             c_out_q, c_out_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] result_next;
`ifdef SERIAL_ADDER_FLAGS_EN
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
`endif

    // Sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at bit 0.
    assign result_next = {fa_s, result_sh_q[WIDTH-1:1]};

    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        result_sh_d = result_sh_q;
        result_d    = result_q;
        count_d     = count_q;
        carry_d     = carry_q;
        c_out_d     = c_out_q;
        overflow_d  = overflow_q;
`ifdef SERIAL_ADDER_FLAGS_EN
        zero_d      = zero_q;
        neg_d       = neg_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d      = a;
                    b_sh_d      = b ^ {WIDTH{sub}};
                    carry_d     = sub;
                    count_d     = '0;
                    result_sh_d = '0;
                    state_d     = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                result_sh_d = result_next;
                a_sh_d      = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d      = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d     = fa_c_out;
                count_d     = count_q + 1'b1;
                if (count_q == CW'(WIDTH - 1)) begin
                    result_d   = result_next;
                    c_out_d    = fa_c_out;
                    // Carry into the MSB differing from carry out signals signed overflow.
                    overflow_d = carry_q ^ fa_c_out;
`ifdef SERIAL_ADDER_FLAGS_EN
                    zero_d     = (result_next == '0);
                    neg_d      = result_next[WIDTH-1];
`endif
                    state_d    = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            result_sh_q <= '0;
            result_q    <= '0;
            count_q     <= '0;
            carry_q     <= 1'b0;
            c_out_q     <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef SERIAL_ADDER_FLAGS_EN
            zero_q      <= 1'b0;
            neg_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            result_sh_q <= result_sh_d;
            result_q    <= result_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            c_out_q     <= c_out_d;
            overflow_q  <= overflow_d;
`ifdef SERIAL_ADDER_FLAGS_EN
            zero_q      <= zero_d;
            neg_q       <= neg_d;
`endif
        end
    end

    assign busy     = (state_q == S_RUN);
    assign done     = (state_q == S_DONE);
    assign result   = result_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;
`ifdef SERIAL_ADDER_FLAGS_EN
    assign zero     = zero_q;
    assign neg      = neg_q;
`endif

    // Shared adder inputs are forced low whenever this sequencer does not own it.
    assign fa_a    = busy & a_sh_q[0];
    assign fa_b    = busy & b_sh_q[0];
    assign fa_c_in = busy & carry_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - randomized scoreboard bench for serial_adder_ctrl with external full adder model
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, c_out, overflow;
    logic [W-1:0] result;
    logic         fa_a, fa_b, fa_c_in, fa_s, fa_c_out;
`ifdef SERIAL_ADDER_FLAGS_EN
    logic         zero, neg;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .c_out(c_out), .overflow(overflow),
`ifdef SERIAL_ADDER_FLAGS_EN
        .zero(zero), .neg(neg),
`endif
        .fa_a(fa_a), .fa_b(fa_b), .fa_c_in(fa_c_in), .fa_s(fa_s), .fa_c_out(fa_c_out)
    );

    assign fa_s     = fa_a ^ fa_b ^ fa_c_in;
    assign fa_c_out = (fa_a & fa_b) | (fa_a & fa_c_in) | (fa_b & fa_c_in);

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic         co;
        logic         ov;
        int           due;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] bx;
        logic         sub;
        int           s;
    } op_t;

    exp_t exp_q[$];
    op_t  op_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int prev_done_cyc = -100;
    int last_gap = 0;
    logic [W-1:0] last_res = '0;
    logic         last_co = 1'b0;
    logic         last_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input bit ok, input string name, input longint act, input longint req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                   input logic ss, input int due);
        exp_t e;
        int ua = int'(aa);
        int ub = int'(bb);
        int sa = int'($signed(aa));
        int sb = int'($signed(bb));
        int tv = ss ? sa - sb : sa + sb;
        e.res = W'(ss ? ua - ub : ua + ub);
        e.co  = ss ? (ua >= ub) : (ua + ub >= (1 << W));
        e.ov  = (tv > (1 << (W - 1)) - 1) || (tv < -(1 << (W - 1)));
        e.due = due;
        return e;
    endfunction

    // One cycle of stimulus; an op is accepted when start meets a non-running sequencer.
    task automatic drive(input logic s, input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss);
        op_t o;
        @(negedge clk);
        start = s;
        a = aa;
        b = bb;
        sub = ss;
        if (s && !busy && rst_n) begin
            exp_q.push_back(model(aa, bb, ss, cyc + 1 + W));
            o.a = aa;
            o.bx = ss ? ~bb : bb;
            o.sub = ss;
            o.s = cyc + 1;
            op_q.push_back(o);
        end
    endtask

    task automatic op(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic ss);
        drive(1'b1, aa, bb, ss);
        repeat (W + 2) drive(1'b0, W'($urandom), W'($urandom), 1'($urandom));
    endtask

    always @(negedge clk) begin : monitor
        op_t  o;
        exp_t e;
        int   i;
        int   m;
        int   cin;
        if (rst_n) begin
            if (busy) begin
                if (op_q.size() == 0) begin
                    chk(1'b0, "busy_without_op", 1, 0);
                end else begin
                    o = op_q[0];
                    i = cyc - o.s;
                    m = (1 << i) - 1;
                    cin = ((int'(o.a) & m) + (int'(o.bx) & m) + int'(o.sub)) >> i;
                    chk(i < W, "busy_length", i, W - 1);
                    chk(fa_a == o.a[i % W], "fa_a", fa_a, o.a[i % W]);
                    chk(fa_b == o.bx[i % W], "fa_b", fa_b, o.bx[i % W]);
                    chk(fa_c_in == cin[0], "fa_c_in", fa_c_in, cin[0]);
                    if (i >= W - 1) void'(op_q.pop_front());
                end
            end else begin
                chk({fa_a, fa_b, fa_c_in} == 3'b000, "fa_idle", {fa_a, fa_b, fa_c_in}, 0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cyc == e.due, "latency", cyc, e.due);
                    chk(result == e.res, "result", result, e.res);
                    chk(c_out == e.co, "c_out", c_out, e.co);
                    chk(overflow == e.ov, "overflow", overflow, e.ov);
`ifdef SERIAL_ADDER_FLAGS_EN
                    chk(zero == (e.res == '0), "zero", zero, e.res == '0);
                    chk(neg == e.res[W-1], "neg", neg, e.res[W-1]);
`endif
                    last_res = e.res;
                    last_co = e.co;
                    last_ov = e.ov;
                end
                last_gap = cyc - prev_done_cyc;
                prev_done_cyc = cyc;
            end else begin
                chk({result, c_out, overflow} == {last_res, last_co, last_ov}, "hold",
                    {result, c_out, overflow}, {last_res, last_co, last_ov});
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({busy, done, result, c_out, overflow, fa_a, fa_b, fa_c_in} == '0, name,
            {busy, done, result, c_out, overflow, fa_a, fa_b, fa_c_in}, 0);
    endtask

    initial begin
        #3;
        check_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op(8'd5, 8'd3, 1'b0);
        chk(result == 8'd8 && c_out == 1'b0 && overflow == 1'b0, "dir_5p3", {result, c_out, overflow}, {8'd8, 2'b00});
        op(8'd200, 8'd100, 1'b0);
        chk(result == 8'd44 && c_out == 1'b1 && overflow == 1'b0, "dir_200p100", {result, c_out, overflow}, {8'd44, 2'b10});
        op(8'd127, 8'd1, 1'b0);
        chk(result == 8'd128 && overflow == 1'b1, "dir_127p1", {result, overflow}, {8'd128, 1'b1});
        op(8'd10, 8'd3, 1'b1);
        chk(result == 8'd7 && c_out == 1'b1, "dir_10m3", {result, c_out}, {8'd7, 1'b1});
        op(8'd3, 8'd10, 1'b1);
        chk(result == 8'd249 && c_out == 1'b0 && overflow == 1'b0, "dir_3m10", {result, c_out, overflow}, {8'd249, 2'b00});
        op(8'd5, 8'd5, 1'b1);
        chk(result == 8'd0, "dir_5m5", result, 0);

        // Held start: back-to-back ops with no idle cycle in between.
        repeat (3 * (W + 1) + 1) drive(1'b1, 8'd1, 8'd1, 1'b0);
        repeat (W + 3) drive(1'b0, 8'd0, 8'd0, 1'b0);
        chk(last_gap == W + 1, "b2b_gap", last_gap, W + 1);
        chk(result == 8'd2, "b2b_result", result, 2);

        // Abort mid-run.
        drive(1'b1, 8'h55, 8'h33, 1'b0);
        repeat (4) drive(1'b0, W'($urandom), W'($urandom), 1'b0);
        #2 rst_n = 1'b0;
        #1 check_all_zero("reset_mid_run");
        exp_q.delete();
        op_q.delete();
        last_res = '0;
        last_co = 1'b0;
        last_ov = 1'b0;
        @(negedge clk);
        check_all_zero("reset_held");
        rst_n = 1'b1;
        op(8'hFF, 8'h01, 1'b0);
        chk(result == 8'h00 && c_out == 1'b1, "after_reset_ff_p1", {result, c_out}, {8'h00, 1'b1});

        // Random traffic, including start/operand toggling while running.
        for (int k = 0; k < 400; k++)
            drive(1'($urandom_range(0, 2) == 0), W'($urandom), W'($urandom), 1'($urandom));

        for (int k = 0; k < 4 * W && exp_q.size() != 0; k++)
            drive(1'b0, 8'd0, 8'd0, 1'b0);
        chk(exp_q.size() == 0, "drain", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
